// File: rtl/mem_arbiter_pkg.sv
// Shared types and widths for the RAM arbiter between the CPU datapath and one external requester.
package mem_arbiter_pkg;

    localparam int MEM_ADDR_W = 12;
    localparam int MEM_DATA_W = 4;
    localparam int WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        MEM_ARB_IDLE   = 2'd0,
        MEM_ARB_RD_CAP = 2'd1,
        MEM_ARB_ACK    = 2'd2
    } mem_arb_state;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle around the arbiter: CPU port, external requester port and RAM macro port.
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic                  cpu_mem_en;
    logic                  cpu_write_en;
    logic [MEM_ADDR_W-1:0] cpu_addr;
    logic [MEM_DATA_W-1:0] cpu_write_data;
    logic [MEM_DATA_W-1:0] cpu_read_data;
    logic                  cpu_halt;

    logic                  ext_req;
    logic                  ext_write;
    logic [MEM_ADDR_W-1:0] ext_addr;
    logic [MEM_DATA_W-1:0] ext_write_data;
    logic                  ext_ack;
    logic [MEM_DATA_W-1:0] ext_read_data;

    logic [MEM_ADDR_W-1:0] ram_addr;
    logic                  ram_write_en;
    logic [MEM_DATA_W-1:0] ram_write_data;
    logic [MEM_DATA_W-1:0] ram_read_data;

    modport slave (
        input  cpu_mem_en, cpu_write_en, cpu_addr, cpu_write_data,
        input  ext_req, ext_write, ext_addr, ext_write_data,
        input  ram_read_data,
        output cpu_read_data, cpu_halt, ext_ack, ext_read_data,
        output ram_addr, ram_write_en, ram_write_data
    );

    modport master (
        output cpu_mem_en, cpu_write_en, cpu_addr, cpu_write_data,
        output ext_req, ext_write, ext_addr, ext_write_data,
        output ram_read_data,
        input  cpu_read_data, cpu_halt, ext_ack, ext_read_data,
        input  ram_addr, ram_write_en, ram_write_data
    );

endinterface

// File: rtl/mem_arb_starve.sv
// Starvation guard: saturating count of blocked external cycles and a one-cycle CPU halt pulse.
module mem_arb_starve
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic idle_i,
    input  logic ext_req_i,
    input  logic grant_i,
    output logic cpu_halt_o
);

    localparam logic [WAIT_CNT_W-1:0] LIMIT = WAIT_CNT_W'(STARVE_LIMIT);

    logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic                  cpu_halt_q, cpu_halt_d;
    logic                  blocked;

    assign blocked = idle_i && ext_req_i && !grant_i;

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (grant_i || (idle_i && !ext_req_i)) begin
            wait_cnt_d = '0;
        end else if (blocked && (wait_cnt_q != LIMIT)) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
        // Re-arms every other cycle if the CPU ignores the halt and keeps blocking.
        cpu_halt_d = blocked && (wait_cnt_q == LIMIT) && !cpu_halt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_q <= '0;
            cpu_halt_q <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            cpu_halt_q <= cpu_halt_d;
        end
    end

    assign cpu_halt_o = cpu_halt_q;

endmodule

// File: rtl/mem_arbiter.sv
// RAM arbiter: CPU has fixed priority, external port uses idle cycles.
// Define MEM_ARB_STARVE_EN to compile in the starvation guard that briefly halts the CPU.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 8
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    mem_arb_state          state_q;
    logic                  ext_ack_q;
    logic [MEM_DATA_W-1:0] ext_read_data_q;
    logic                  grant;
    logic                  cpu_halt;

    assign grant = (state_q == MEM_ARB_IDLE) && bus.ext_req && !bus.cpu_mem_en;

    always_comb begin
        bus.ram_addr       = bus.cpu_addr;
        bus.ram_write_data = bus.cpu_write_data;
        bus.ram_write_en   = 1'b0;
        if (bus.cpu_mem_en) begin
            bus.ram_write_en = bus.cpu_write_en;
        end else if (grant) begin
            bus.ram_addr       = bus.ext_addr;
            bus.ram_write_data = bus.ext_write_data;
            bus.ram_write_en   = bus.ext_write;
        end
        if (reset) begin
            bus.ram_write_en = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= MEM_ARB_IDLE;
            ext_ack_q       <= 1'b0;
            ext_read_data_q <= '0;
        end else begin
            ext_ack_q <= 1'b0;
            case (state_q)
                MEM_ARB_IDLE: begin
                    if (grant) begin
                        if (bus.ext_write) begin
                            state_q   <= MEM_ARB_ACK;
                            ext_ack_q <= 1'b1;
                        end else begin
                            state_q <= MEM_ARB_RD_CAP;
                        end
                    end
                end
                MEM_ARB_RD_CAP: begin
                    ext_read_data_q <= bus.ram_read_data;
                    state_q         <= MEM_ARB_ACK;
                    ext_ack_q       <= 1'b1;
                end
                MEM_ARB_ACK: state_q <= MEM_ARB_IDLE;
                default:     state_q <= MEM_ARB_IDLE;
            endcase
        end
    end

`ifdef MEM_ARB_STARVE_EN
    mem_arb_starve #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk        (clk),
        .reset      (reset),
        .idle_i     (state_q == MEM_ARB_IDLE),
        .ext_req_i  (bus.ext_req),
        .grant_i    (grant),
        .cpu_halt_o (cpu_halt)
    );

    // The sequencer must release the RAM while halted; otherwise the CPU still wins.
    a_halt_honoured: assert property (@(posedge clk) disable iff (reset)
        !(cpu_halt && bus.cpu_mem_en));
`else
    assign cpu_halt = 1'b0;
`endif

    a_limit_range: assert property (@(posedge clk)
        (STARVE_LIMIT >= 1) && (STARVE_LIMIT <= 15));

    assign bus.cpu_read_data = bus.ram_read_data;
    assign bus.cpu_halt      = cpu_halt;
    assign bus.ext_ack       = ext_ack_q;
    assign bus.ext_read_data = ext_read_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: table of external transactions with a scoreboard, plus corner sequences.
module tb_mem_arbiter;

    localparam int LIMIT = 8;

    typedef struct {
        bit          we;
        logic [11:0] addr;
        logic [3:0]  wdata;
        int          busy;
        logic [3:0]  exp_rd;
    } vec_t;

    typedef struct {
        bit         is_read;
        logic [3:0] data;
        int         ack_cyc;
    } sb_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    vec_t vecs [12];
    sb_t  sb_q [$];
    logic [3:0] ram [0:4095];

    mem_arbiter_if bus ();

    mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.ram_write_en) ram[bus.ram_addr] <= bus.ram_write_data;
        bus.ram_read_data <= ram[bus.ram_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic pop_check(input int cyc, input logic [3:0] rd);
        sb_t e;
        if (sb_q.size() == 0) begin
            check("sb_unexpected_ack", 32'(1), 32'(0));
        end else begin
            e = sb_q.pop_front();
            check("ack_latency", 32'(cyc), 32'(e.ack_cyc));
            if (e.is_read) check("ext_read_data", 32'(rd), 32'(e.data));
        end
    endtask

    task automatic ext_txn(input bit we, input logic [11:0] addr, input logic [3:0] wdata,
                           input int busy, input logic [3:0] exp_rd);
        sb_t         e;
        bit          acked;
        logic [11:0] caddr;
        e.is_read = !we;
        e.data    = exp_rd;
        e.ack_cyc = busy + (we ? 1 : 2);
        sb_q.push_back(e);
        acked = 1'b0;
        for (int cyc = 0; cyc < 40 && !acked; cyc++) begin
            @(negedge clk);
            caddr              = 12'hE00 + cyc[11:0];
            bus.ext_req        = 1'b1;
            bus.ext_write      = we;
            bus.ext_addr       = addr;
            bus.ext_write_data = wdata;
            bus.cpu_mem_en     = (cyc < busy);
            bus.cpu_write_en   = 1'b0;
            bus.cpu_addr       = caddr;
            #1;
            if (cyc < busy) begin
                check("cpu_priority_addr", 32'(bus.ram_addr), 32'(caddr));
                check("cpu_priority_we", 32'(bus.ram_write_en), 32'(0));
            end
            if (cyc == busy) begin
                check("grant_addr", 32'(bus.ram_addr), 32'(addr));
                check("grant_we", 32'(bus.ram_write_en), 32'(we));
                if (we) check("grant_wdata", 32'(bus.ram_write_data), 32'(wdata));
            end
            if (bus.ext_ack) begin
                acked = 1'b1;
                pop_check(cyc, bus.ext_read_data);
            end
        end
        if (!acked) begin
            check("ack_timeout", 32'(0), 32'(1));
            void'(sb_q.pop_back());
        end
        @(negedge clk);
        bus.ext_req    = 1'b0;
        bus.cpu_mem_en = 1'b0;
        #1;
        check("ack_single_pulse", 32'(bus.ext_ack), 32'(0));
    endtask

    task automatic cpu_read(input logic [11:0] addr, input logic [3:0] exp);
        @(negedge clk);
        bus.cpu_mem_en   = 1'b1;
        bus.cpu_write_en = 1'b0;
        bus.cpu_addr     = addr;
        #1;
        check("cpu_rd_addr", 32'(bus.ram_addr), 32'(addr));
        @(negedge clk);
        bus.cpu_mem_en = 1'b0;
        #1;
        check("cpu_read_data", 32'(bus.cpu_read_data), 32'(exp));
    endtask

    task automatic cpu_write(input logic [11:0] addr, input logic [3:0] data);
        @(negedge clk);
        bus.cpu_mem_en     = 1'b1;
        bus.cpu_write_en   = 1'b1;
        bus.cpu_addr       = addr;
        bus.cpu_write_data = data;
        #1;
        check("cpu_wr_we", 32'(bus.ram_write_en), 32'(1));
        @(negedge clk);
        bus.cpu_mem_en   = 1'b0;
        bus.cpu_write_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int halt_first, halt_cnt, wr_cyc, ack_cyc;

        for (int i = 0; i < 4096; i++) ram[i] = 4'h0;
        vecs[0]  = '{1'b1, 12'h123, 4'hA, 0, 4'h0};
        vecs[1]  = '{1'b1, 12'h0F0, 4'h5, 0, 4'h0};
        vecs[2]  = '{1'b0, 12'h0F0, 4'h0, 0, 4'h5};
        vecs[3]  = '{1'b0, 12'h123, 4'h0, 0, 4'hA};
        vecs[4]  = '{1'b1, 12'h010, 4'hC, 2, 4'h0};
        vecs[5]  = '{1'b0, 12'h010, 4'h0, 3, 4'hC};
        vecs[6]  = '{1'b1, 12'hFFF, 4'hF, 1, 4'h0};
        vecs[7]  = '{1'b0, 12'hFFF, 4'h0, 0, 4'hF};
        vecs[8]  = '{1'b1, 12'h000, 4'h3, 0, 4'h0};
        vecs[9]  = '{1'b0, 12'h000, 4'h0, 1, 4'h3};
        vecs[10] = '{1'b1, 12'h123, 4'h6, 0, 4'h0};
        vecs[11] = '{1'b0, 12'h123, 4'h0, 0, 4'h6};

        reset              = 1'b1;
        bus.cpu_mem_en     = 1'b1;
        bus.cpu_write_en   = 1'b1;
        bus.cpu_addr       = 12'h300;
        bus.cpu_write_data = 4'h9;
        bus.ext_req        = 1'b0;
        bus.ext_write      = 1'b0;
        bus.ext_addr       = 12'h000;
        bus.ext_write_data = 4'h0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_ram_we_forced", 32'(bus.ram_write_en), 32'(0));
        check("rst_cpu_halt", 32'(bus.cpu_halt), 32'(0));
        check("rst_ext_ack", 32'(bus.ext_ack), 32'(0));
        check("rst_ext_read_data", 32'(bus.ext_read_data), 32'(0));
        bus.cpu_mem_en   = 1'b0;
        bus.cpu_write_en = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 12; i++)
            ext_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].busy, vecs[i].exp_rd);

        repeat (3) @(negedge clk);
        #1;
        check("rd_data_hold_idle", 32'(bus.ext_read_data), 32'(6));
        ext_txn(1'b1, 12'h777, 4'h1, 0, 4'h0);
        #1;
        check("rd_data_hold_after_write", 32'(bus.ext_read_data), 32'(6));

        cpu_read(12'h123, 4'h6);
        cpu_read(12'h0F0, 4'h5);
        cpu_write(12'h456, 4'h9);
        ext_txn(1'b0, 12'h456, 4'h0, 0, 4'h9);

`ifdef MEM_ARB_STARVE_EN
        halt_first = -1; halt_cnt = 0; wr_cyc = -1; ack_cyc = -1;
        begin
            sb_t e;
            e.is_read = 1'b0; e.data = 4'h0; e.ack_cyc = LIMIT + 2;
            sb_q.push_back(e);
        end
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            bus.ext_req        = (ack_cyc < 0);
            bus.ext_write      = 1'b1;
            bus.ext_addr       = 12'h200;
            bus.ext_write_data = 4'h7;
            bus.cpu_mem_en     = !bus.cpu_halt;
            bus.cpu_write_en   = 1'b0;
            bus.cpu_addr       = 12'hC00 + cyc[11:0];
            #1;
            if (bus.cpu_halt) begin
                halt_cnt++;
                if (halt_first < 0) halt_first = cyc;
            end
            if (bus.ram_write_en) begin
                wr_cyc = cyc;
                check("starve_grant_addr", 32'(bus.ram_addr), 32'(12'h200));
            end
            if (bus.ext_ack) begin
                ack_cyc = cyc;
                pop_check(cyc, bus.ext_read_data);
            end
        end
        check("starve_halt_cycle", 32'(halt_first), 32'(LIMIT + 1));
        check("starve_halt_width", 32'(halt_cnt), 32'(1));
        check("starve_grant_cycle", 32'(wr_cyc), 32'(LIMIT + 1));
        check("starve_ack_seen", 32'(ack_cyc >= 0), 32'(1));
        bus.ext_req    = 1'b0;
        bus.cpu_mem_en = 1'b0;
        while (sb_q.size() > 0) void'(sb_q.pop_front());
`else
        halt_cnt = 0; wr_cyc = 0; ack_cyc = 0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(negedge clk);
            bus.ext_req        = 1'b1;
            bus.ext_write      = 1'b1;
            bus.ext_addr       = 12'h200;
            bus.ext_write_data = 4'h7;
            bus.cpu_mem_en     = 1'b1;
            bus.cpu_write_en   = 1'b0;
            bus.cpu_addr       = 12'hC00 + cyc[11:0];
            #1;
            if (bus.cpu_halt) halt_cnt++;
            if (bus.ram_write_en) wr_cyc++;
            if (bus.ext_ack) ack_cyc++;
        end
        check("noguard_halt_count", 32'(halt_cnt), 32'(0));
        check("noguard_write_count", 32'(wr_cyc), 32'(0));
        check("noguard_ack_count", 32'(ack_cyc), 32'(0));
        ext_txn(1'b1, 12'h200, 4'h7, 0, 4'h0);
`endif
        ext_txn(1'b0, 12'h200, 4'h0, 0, 4'h7);

        @(negedge clk);
        bus.ext_req    = 1'b1;
        bus.ext_write  = 1'b0;
        bus.ext_addr   = 12'h0F0;
        bus.cpu_mem_en = 1'b0;
        #1;
        check("rstmid_grant_addr", 32'(bus.ram_addr), 32'(12'h0F0));
        @(negedge clk);
        reset              = 1'b1;
        bus.ext_req        = 1'b0;
        bus.cpu_mem_en     = 1'b1;
        bus.cpu_write_en   = 1'b1;
        bus.cpu_addr       = 12'h300;
        bus.cpu_write_data = 4'hD;
        #1;
        check("rstmid_ram_we_forced", 32'(bus.ram_write_en), 32'(0));
        check("rstmid_ext_read_data", 32'(bus.ext_read_data), 32'(0));
        ack_cyc = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            if (cyc == 3) begin
                reset            = 1'b0;
                bus.cpu_mem_en   = 1'b0;
                bus.cpu_write_en = 1'b0;
            end
            #1;
            if (bus.ext_ack) ack_cyc++;
        end
        check("rstmid_no_ack", 32'(ack_cyc), 32'(0));
        check("rstmid_read_data_cleared", 32'(bus.ext_read_data), 32'(0));
        ext_txn(1'b0, 12'h0F0, 4'h0, 0, 4'h5);
        cpu_read(12'h300, 4'h0);

        check("sb_drained", 32'(sb_q.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
